// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// FETCH_MISALIGN_CHECK_EN adds a misalign tag to every buffered entry.
package instr_fetch_pkg;

    typedef enum logic {F_REQ = 1'b0, F_WAIT = 1'b1} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic        misalign;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous {pc, instr} buffer between the memory response and decode.
// Flush empties the buffer in one edge and overrides push/pop.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  din,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one imem request in flight, buffers words for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds out_misalign for the first word after a misaligned redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        out_misalign,
`endif
    output logic [31:0] out_pc_plus4
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          discard;
    logic          started;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  din;
    fetch_entry_t  head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= F_REQ;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_REQ:   if (imem_req && imem_gnt) state_nxt = F_WAIT;
            F_WAIT:  if (imem_rvalid)          state_nxt = F_REQ;
            default: state_nxt = F_REQ;
        endcase
    end

    // Issuing only with a free slot reserves room for the one outstanding response.
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        case (state)
            F_REQ:   imem_req = started && (fifo_count < CW'(FIFO_DEPTH)) && !redirect_valid;
            F_WAIT:  push     = imem_rvalid && !discard && !redirect_valid && (!fifo_full || pop);
            default: ;
        endcase
    end

    assign imem_addr = {pc[31:2], 2'b00};
    assign pop       = !fifo_empty && out_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            discard <= 1'b0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid)            pc <= {redirect_pc[31:2], 2'b00};
            else if (imem_req && imem_gnt) pc <= pc + 32'd4;
            // A response already arriving with the redirect is dropped directly, not via discard.
            if (state == F_WAIT && imem_rvalid)         discard <= 1'b0;
            else if (state == F_WAIT && redirect_valid) discard <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req && imem_gnt) req_pc <= pc;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_pend;
    logic req_mis;

    // The tag follows the first request granted after a misaligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pend <= 1'b0;
            req_mis  <= 1'b0;
        end else begin
            if (redirect_valid)            mis_pend <= |redirect_pc[1:0];
            else if (imem_req && imem_gnt) mis_pend <= 1'b0;
            if (imem_req && imem_gnt)      req_mis  <= mis_pend;
        end
    end

    assign out_misalign = !fifo_empty && head.misalign;
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    always_comb begin
        din       = '0;
        din.pc    = req_pc;
        din.instr = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
        din.misalign = req_mis;
`endif
    end

    instr_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign out_valid    = !fifo_empty;
    assign out_instr    = fifo_empty ? NOP_INSTR : head.instr;
    assign out_pc       = fifo_empty ? pc : head.pc;
    assign out_pc_plus4 = out_pc + 32'd4;

endmodule
